// File: rtl/rx_cmd_dispatch.sv
`default_nettype none
// rx_cmd_dispatch: device-filtered command queue dispatching to four cfg ports over req/ack.
// Optional macro RX_DISP_BCAST_EN: dev 8'hFF broadcasts to all four ports. Rev 1.0
module rx_cmd_dispatch #(
  parameter logic [7:0]  DEV_ID      = 8'h01,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [19:0] ACK_TIMEOUT = 20'd100000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic [7:0] cmdr_dev,
  input  logic [7:0] cmdr_mod,
  input  logic [7:0] cmdr_addr,
  input  logic [7:0] cmdr_data,
  input  logic       cmdr_vld,
  output logic [3:0] cfg_req,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  input  logic [3:0] cfg_ack,
  output logic       busy,
  output logic       fifo_full,
  output logic [7:0] drop_cnt,
  output logic [7:0] tmo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef RX_DISP_BCAST_EN
  localparam int EW = 19;
`else
  localparam int EW = 18;
`endif
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd6;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [EW-1:0] push_entry, head;
  logic          fifo_empty, dev_ok, push, pop;

  logic [2:0]  state, state_nxt;
  logic [1:0]  cur_mod;
  logic [19:0] tmo_ctr;
  logic [3:0]  req_vec;
  logic        ack_hit, tmo_hit;

`ifdef RX_DISP_BCAST_EN
  logic       cmd_bcast, cur_bcast;
  logic [3:0] ack_seen;
  assign cmd_bcast  = (cmdr_dev == 8'hFF);
  assign dev_ok     = (cmdr_dev == DEV_ID) || cmd_bcast;
  assign push_entry = {cmd_bcast, cmdr_mod[1:0], cmdr_addr, cmdr_data};
  assign req_vec    = cur_bcast ? 4'hF : (4'b0001 << cur_mod);
  assign ack_hit    = cur_bcast ? (&(ack_seen | cfg_ack)) : cfg_ack[cur_mod];
`else
  assign dev_ok     = (cmdr_dev == DEV_ID);
  assign push_entry = {cmdr_mod[1:0], cmdr_addr, cmdr_data};
  assign req_vec    = 4'b0001 << cur_mod;
  assign ack_hit    = cfg_ack[cur_mod];
`endif

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = cmdr_vld && dev_ok && (cmdr_mod[7:2] == 6'd0) && !fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign tmo_hit    = (tmo_ctr == ACK_TIMEOUT - 20'd1);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (cmdr_vld && !push && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_REQ;
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT: begin
        // A late ack still beats the timeout landing in the same cycle.
        if (ack_hit)      state_nxt = S_DONE;
        else if (tmo_hit) state_nxt = S_FAIL;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_FAIL:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_req = 4'b0000;
    pop     = 1'b0;
    case (state)
      S_IDLE:        pop     = !fifo_empty;
      S_REQ, S_WAIT: cfg_req = req_vec;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cur_mod  <= 2'd0;
      cfg_addr <= 8'd0;
      cfg_data <= 8'd0;
      tmo_ctr  <= 20'd0;
      tmo_cnt  <= 8'd0;
    end else begin
      if (pop) {cur_mod, cfg_addr, cfg_data} <= head[17:0];
      if (state == S_REQ)       tmo_ctr <= 20'd0;
      else if (state == S_WAIT) tmo_ctr <= tmo_ctr + 20'd1;
      if ((state == S_FAIL) && (tmo_cnt != 8'hFF)) tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

`ifdef RX_DISP_BCAST_EN
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cur_bcast <= 1'b0;
      ack_seen  <= 4'd0;
    end else begin
      if (pop) cur_bcast <= head[18];
      if (state == S_REQ)       ack_seen <= 4'd0;
      else if (state == S_WAIT) ack_seen <= ack_seen | cfg_ack;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/rx_cmd_dispatch.md
Name: rx_cmd_dispatch

Overview:
- Sits downstream of the UART command decoder.
- Accepts decoded 4-byte commands (dev/mod/addr/data plus a single-cycle valid).
- Filters them by device ID and queues them in a small FIFO.
- Dispatches each one to one of four module configuration ports using a req/ack handshake, with an ack timeout and saturating error counters.

Parameters:
DEV_ID, 8'h01, device ID of this FPGA; commands with any other cmdr_dev are dropped
FIFO_DEPTH, 4, command queue depth; power of 2, minimum 2
ACK_TIMEOUT, 20'd100000, clk_sys cycles in S_WAIT before abandoning a command

Ports:
clk_sys  in  1  system clock
rst  in  1  synchronous reset, active-high
cmdr_dev  in  8  decoded device byte
cmdr_mod  in  8  decoded module byte; valid targets are 0..3
cmdr_addr  in  8  decoded register address
cmdr_data  in  8  decoded register data
cmdr_vld  in  1  single-cycle pulse; qualifies cmdr_* in the same cycle
cfg_req  out  4  one-hot request to module N, held until ack or timeout
cfg_addr  out  8  register address, stable while any cfg_req bit is high
cfg_data  out  8  register data, stable while any cfg_req bit is high
cfg_ack  in  4  per-module acknowledge; only bit cur_mod is honoured
busy  out  1  high when FSM not in S_IDLE or FIFO not empty
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
drop_cnt  out  8  saturating count of rejected commands
tmo_cnt  out  8  saturating count of ack timeouts

Behaviour:
- Clock and reset: one clock, clk_sys. rst is synchronous, active-high, and has priority over all other logic.
- Reset state: FSM in S_IDLE; FIFO emptied (pointers 0); cfg_req=0, cfg_addr=0, cfg_data=0, drop_cnt=0, tmo_cnt=0, busy=0, fifo_full=0.
- Accept rule: a command is accepted when all of the following hold: cmdr_vld=1, cmdr_dev==DEV_ID, cmdr_mod<4 (upper 6 bits zero), and the FIFO is not full.
  - Accepted: the 18-bit entry {mod[1:0], addr, data} is pushed.
  - Rejected (cmdr_vld=1 but any condition fails): drop_cnt increments, saturating at 8'hFF.
- Full with simultaneous pop: if a pop occurs in the same cycle the FIFO is full, the push is still refused. Fullness is evaluated on registered state; there is no bypass.
- FIFO implementation: write/read pointers carry one extra wrap bit; pointers wrap naturally modulo 2*FIFO_DEPTH. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- FSM states: S_IDLE=0, S_REQ=1, S_WAIT=2, S_DONE=3, S_FAIL=6.
  - S_IDLE: if the FIFO is not empty, pop the head into cur_mod/cfg_addr/cfg_data and go to S_REQ; otherwise stay.
  - S_REQ: drive cfg_req = 1<<cur_mod, clear the timeout counter, go to S_WAIT.
  - S_WAIT: keep cfg_req asserted; the counter increments each cycle.
    - cfg_ack[cur_mod]=1 -> S_DONE.
    - Otherwise, counter == ACK_TIMEOUT-1 -> S_FAIL.
    - Ack in the same cycle as the timeout -> ack wins, go to S_DONE.
    - Acks on other bits are ignored.
  - S_DONE: cfg_req=0 for one cycle, then S_IDLE.
  - S_FAIL: cfg_req=0; tmo_cnt increments (saturating at 8'hFF); then S_IDLE.
- Handshake latency and throughput:
  - cfg_req rises 2 cycles after cmdr_vld into an empty FIFO while idle: push in cycle N, pop in N+1, req high in N+2.
  - cfg_req falls the cycle after ack is sampled.
  - Minimum spacing between back-to-back requests is 3 idle-req cycles: DONE, IDLE, REQ.
- cfg_addr/cfg_data: hold their last values after completion; they are not cleared.
- Counter widths: the timeout counter is 20 bits.
- Reset mid-transaction: cfg_req drops in the cycle after rst is sampled, and queued commands are discarded.

Optional Feature:
Macro RX_DISP_BCAST_EN.
- Defined: cmdr_dev==8'hFF is also accepted. A broadcast entry carries a flag bit; in S_REQ it drives cfg_req=4'hF. S_WAIT exits to S_DONE only when all four ack bits have been seen high, each latched sticky per bit. The timeout applies to the whole broadcast. tmo_cnt increments once.
- Not defined: 8'hFF is treated as a non-matching device and counted in drop_cnt. Entry width stays 18 bits.

Test Plan:
1. Basic write: cmdr_vld with dev=01, mod=02, addr=10, data=A5; module 2 acks 3 cycles after req -> cfg_req=4'b0100 two cycles after vld, cfg_addr=10, cfg_data=A5, cfg_req cleared the cycle after ack, busy back to 0; drop_cnt=0.
2. Filtering: vld with dev=02 then dev=01/mod=05 -> no cfg_req, drop_cnt=2; with RX_DISP_BCAST_EN undefined, dev=FF -> drop_cnt=3.
3. FIFO fill: cfg_ack held 0, six valid commands for mod 0 at 2-cycle spacing -> first popped into S_WAIT; next 4 fill FIFO (fifo_full=1); 6th dropped, drop_cnt=1; after acking each, all 5 issued in order with correct addr/data.
4. Timeout: ACK_TIMEOUT=16, no ack -> cfg_req high exactly 16 cycles in S_WAIT, then S_FAIL, tmo_cnt=1; next queued command then issued; ack on wrong bit (cfg_ack=4'b0001 for mod 3) does not complete.
5. Reset mid-operation: assert rst while in S_WAIT with 2 entries queued -> next cycle cfg_req=0, busy=0, counters 0; no stale command issued after rst deasserts.
6. Broadcast (RX_DISP_BCAST_EN defined): dev=FF, mod=00, addr=20, data=3C; acks arrive on bits 0,2,1,3 in separate cycles -> cfg_req=4'hF until the cycle after the last ack, single S_DONE, tmo_cnt unchanged.
